pwm_center_multi: RTL and testbench



---
 rtl/pwm_center_multi.sv | 199 +++++++++++++++++++
 tb/tb_pwm_center_multi.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_center_multi.sv
// pwm_center_multi -- multi-channel center-aligned PWM generator.
//
// One shared up/down carrier (0..P-1 up, P-1..0 down, 2P cycles per period)
// is compared against a per-channel duty. Period and duties are written via
// a valid/ready shadow register and only become active at the period
// boundary (or immediately while the carrier is parked by enable=0).
//
// Optional feature macro: PWM_DEADTIME_EN (adds pwm_out_n and dead-time
// insertion of DEADTIME cycles on every rising edge of either output).
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-high
//   enable        run carrier when high, park (outputs low) when low
//   cfg_valid     configuration offered
//   cfg_ready     shadow free (!pending && !reset)
//   cfg_period    requested period P (0 treated as 1)
//   cfg_duty      duty for channel i in bits [i*WIDTH +: WIDTH]
//   pwm_out       registered PWM outputs
//   period_start  one-cycle pulse on the first cycle of each period
//   pwm_out_n     complementary outputs (PWM_DEADTIME_EN only)

module pwm_center_multi #(
   parameter int unsigned WIDTH        = 10,
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned RESET_PERIOD = 1023,
   parameter int unsigned DEADTIME     = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [WIDTH-1:0]          cfg_period,
   input  logic [CHANNELS*WIDTH-1:0] cfg_duty,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic                      period_start
`ifdef PWM_DEADTIME_EN
   ,
   output logic [CHANNELS-1:0]       pwm_out_n
`endif
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [WIDTH-1:0]          cnt_q, cnt_d;
   dir_t                      dir_q, dir_d;
   logic [WIDTH-1:0]          per_act_q, per_act_d;
   logic [WIDTH-1:0]          per_sh_q, per_sh_d;
   logic [CHANNELS*WIDTH-1:0] duty_act_q, duty_act_d;
   logic [CHANNELS*WIDTH-1:0] duty_sh_q, duty_sh_d;
   logic                      pending_q, pending_d;
   logic [CHANNELS-1:0]       pwm_q, pwm_d;
   logic                      period_start_q, period_start_d;
   logic [CHANNELS-1:0]       raw;
   logic                      accept;
   logic                      boundary;
   logic                      commit;

   assign cfg_ready    = !pending_q && !reset;
   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;

   // Carrier and shadow/commit handling. Accept needs !pending and commit
   // needs pending, so the two never act on the same edge.
   always_comb begin : carrier_cfg
      accept     = cfg_valid && cfg_ready;
      boundary   = enable && (dir_q == DIR_DOWN) && (cnt_q == '0);
      commit     = pending_q && (boundary || !enable);

      cnt_d      = cnt_q;
      dir_d      = dir_q;
      per_act_d  = per_act_q;
      duty_act_d = duty_act_q;
      per_sh_d   = per_sh_q;
      duty_sh_d  = duty_sh_q;
      pending_d  = pending_q;

      if (!enable) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (dir_q == DIR_UP) begin
         if (cnt_q == per_act_q - WIDTH'(1)) begin
            dir_d = DIR_DOWN;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end else begin
         if (cnt_q == '0) begin
            dir_d = DIR_UP;
         end else begin
            cnt_d = cnt_q - WIDTH'(1);
         end
      end

      if (commit) begin
         per_act_d  = per_sh_q;
         duty_act_d = duty_sh_q;
         pending_d  = 1'b0;
      end

      if (accept) begin
         per_sh_d  = (cfg_period == '0) ? WIDTH'(1) : cfg_period;
         duty_sh_d = cfg_duty;
         pending_d = 1'b1;
      end
   end

   always_comb begin : compare
      raw = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         raw[i] = (cnt_q < duty_act_q[i*WIDTH +: WIDTH]);
      end
      period_start_d = enable && (cnt_q == '0) && (dir_q == DIR_UP);
   end

`ifdef PWM_DEADTIME_EN
   localparam int unsigned RW = $clog2(DEADTIME + 2);

   logic [RW-1:0]       hi_run_q [CHANNELS];
   logic [RW-1:0]       hi_run_d [CHANNELS];
   logic [RW-1:0]       lo_run_q [CHANNELS];
   logic [RW-1:0]       lo_run_d [CHANNELS];
   logic [CHANNELS-1:0] pwm_n_q, pwm_n_d;

   assign pwm_out_n = pwm_n_q;

   // hi_run/lo_run count prior consecutive cycles of raw high/low, saturating
   // at DEADTIME; an output may only rise once its run has reached DEADTIME.
   always_comb begin : dead_time
      pwm_d   = '0;
      pwm_n_d = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         hi_run_d[i] = '0;
         lo_run_d[i] = '0;
         if (enable) begin
            if (raw[i]) begin
               hi_run_d[i] = (hi_run_q[i] < RW'(DEADTIME)) ? hi_run_q[i] + RW'(1) : hi_run_q[i];
               pwm_d[i]    = (hi_run_q[i] >= RW'(DEADTIME));
            end else begin
               lo_run_d[i] = (lo_run_q[i] < RW'(DEADTIME)) ? lo_run_q[i] + RW'(1) : lo_run_q[i];
               pwm_n_d[i]  = (lo_run_q[i] >= RW'(DEADTIME));
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_n_q <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            hi_run_q[i] <= '0;
            lo_run_q[i] <= '0;
         end
      end else begin
         pwm_n_q <= pwm_n_d;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            hi_run_q[i] <= hi_run_d[i];
            lo_run_q[i] <= lo_run_d[i];
         end
      end
   end
`else
   logic [31:0] deadtime_unused;
   assign deadtime_unused = DEADTIME;

   always_comb begin : plain_out
      pwm_d = enable ? raw : '0;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q          <= '0;
         dir_q          <= DIR_UP;
         per_act_q      <= WIDTH'(RESET_PERIOD);
         duty_act_q     <= '0;
         per_sh_q       <= WIDTH'(RESET_PERIOD);
         duty_sh_q      <= '0;
         pending_q      <= 1'b0;
         pwm_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         dir_q          <= dir_d;
         per_act_q      <= per_act_d;
         duty_act_q     <= duty_act_d;
         per_sh_q       <= per_sh_d;
         duty_sh_q      <= duty_sh_d;
         pending_q      <= pending_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
      end
   end

endmodule

// File: tb/tb_pwm_center_multi.sv
// Self-checking bench for pwm_center_multi: a period-position reference
// model checked every cycle, a table of programmed periods/duties with
// hand-derived per-period output patterns, and hand-written corner cases.

module tb_pwm_center_multi;

   localparam int W  = 10;
   localparam int CH = 4;
   localparam int RP = 1023;
   localparam int DT = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              enable;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [W-1:0]      cfg_period;
   logic [CH*W-1:0]   cfg_duty;
   logic [CH-1:0]     pwm_out;
   logic              period_start;
`ifdef PWM_DEADTIME_EN
   logic [CH-1:0]     pwm_out_n;
`endif

   int total = 0;
   int bad   = 0;

   // reference model: position t within the 2P-cycle period
   int            m_t, m_p, m_pend, m_sh_p;
   int            m_duty [CH];
   int            m_sh_duty [CH];
   logic [CH-1:0] e_pwm;
   logic          e_ps;
`ifdef PWM_DEADTIME_EN
   logic [CH-1:0] e_pwm_n;
   int            hist [CH][DT];
`endif

   typedef struct packed {
      logic [W-1:0]     period;
      logic [CH*W-1:0]  duty;
      logic [CH*16-1:0] pat;
      logic [7:0]       len;
   } vec_t;

   vec_t tbl [4];

   pwm_center_multi #(
      .WIDTH        (W),
      .CHANNELS     (CH),
      .RESET_PERIOD (RP),
      .DEADTIME     (DT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_period   (cfg_period),
      .cfg_duty     (cfg_duty),
      .pwm_out      (pwm_out),
      .period_start (period_start)
`ifdef PWM_DEADTIME_EN
      ,
      .pwm_out_n    (pwm_out_n)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int car(input int t, input int p);
      return (t < p) ? t : 2 * p - 1 - t;
   endfunction

   function automatic logic [CH*W-1:0] pack4(input int a, input int b, input int c, input int d);
      return {W'(d), W'(c), W'(b), W'(a)};
   endfunction

   function automatic vec_t mk(input int p, input logic [CH*W-1:0] d,
                               input logic [15:0] q0, input logic [15:0] q1,
                               input logic [15:0] q2, input logic [15:0] q3,
                               input int len);
      vec_t v;
      v.period = W'(p);
      v.duty   = d;
      v.pat    = {q3, q2, q1, q0};
      v.len    = 8'(len);
      return v;
   endfunction

   task automatic model_edge();
      int c;
      bit raw;
      bit acc;
      bit wrap;
      if (reset) begin
         m_t    = 0;
         m_p    = RP;
         m_pend = 0;
         m_sh_p = RP;
         e_pwm  = '0;
         e_ps   = 1'b0;
         for (int i = 0; i < CH; i++) m_duty[i] = 0;
`ifdef PWM_DEADTIME_EN
         e_pwm_n = '0;
         for (int i = 0; i < CH; i++)
            for (int k = 0; k < DT; k++) hist[i][k] = -1;
`endif
      end else begin
         acc = cfg_valid && (m_pend == 0);
         c   = car(m_t, m_p);
         for (int i = 0; i < CH; i++) begin
            raw = (c < m_duty[i]);
`ifdef PWM_DEADTIME_EN
            begin
               bit all_hi;
               bit all_lo;
               all_hi = 1'b1;
               all_lo = 1'b1;
               for (int k = 0; k < DT; k++) begin
                  if (hist[i][k] != 1) all_hi = 1'b0;
                  if (hist[i][k] != 0) all_lo = 1'b0;
               end
               e_pwm[i]   = enable && raw && all_hi;
               e_pwm_n[i] = enable && !raw && all_lo;
               for (int k = DT - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
               hist[i][0] = enable ? int'(raw) : -1;
            end
`else
            e_pwm[i] = enable && raw;
`endif
         end
         e_ps = enable && (m_t == 0);
         wrap = !enable || (m_t == 2 * m_p - 1);
         m_t  = wrap ? 0 : m_t + 1;
         if (wrap && m_pend != 0) begin
            m_p = m_sh_p;
            for (int i = 0; i < CH; i++) m_duty[i] = m_sh_duty[i];
            m_pend = 0;
         end
         if (acc) begin
            m_sh_p = (cfg_period == '0) ? 1 : int'(cfg_period);
            for (int i = 0; i < CH; i++) m_sh_duty[i] = int'(cfg_duty[i*W +: W]);
            m_pend = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      chk("pwm_out", int'(pwm_out), int'(e_pwm));
      chk("period_start", int'(period_start), int'(e_ps));
      chk("cfg_ready", int'(cfg_ready), (m_pend == 0 && !reset) ? 1 : 0);
`ifdef PWM_DEADTIME_EN
      chk("pwm_out_n", int'(pwm_out_n), int'(e_pwm_n));
      chk("no_overlap", int'(pwm_out & pwm_out_n), 0);
`endif
   endtask

   task automatic wait_ps();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!period_start && n < 5000);
      if (!period_start) chk("wait_period_start", 0, 1);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cfg_ready && n < 5000) begin
         step();
         n++;
      end
      chk("wait_ready", int'(cfg_ready), 1);
   endtask

   task automatic offer(input int p, input logic [CH*W-1:0] d);
      cfg_period = W'(p);
      cfg_duty   = d;
      cfg_valid  = 1'b1;
      wait_ready();
      step();
      cfg_valid  = 1'b0;
   endtask

   // offer, wait for the commit, then land on the first period using it
   task automatic load(input int p, input logic [CH*W-1:0] d);
      offer(p, d);
      wait_ready();
      wait_ps();
   endtask

   task automatic capture(input int len, output logic [CH*16-1:0] pats);
      pats = '0;
      for (int j = 0; j < len; j++) begin
         for (int c = 0; c < CH; c++) pats[c*16 +: 16] = {pats[c*16 +: 15], pwm_out[c]};
         if (j < len - 1) step();
      end
   endtask

   task automatic cmp_pat(input string name, input int act, input int exp);
`ifndef PWM_DEADTIME_EN
      chk(name, act, exp);
`endif
   endtask

   initial begin
      logic [CH*16-1:0] got;
      logic [15:0]      pat1;
      int               n;

      tbl[0] = mk(4, pack4(0, 2, 4, 7), 8'b00000000, 8'b11000011, 8'b11111111, 8'b11111111, 8);
      tbl[1] = mk(4, pack4(1, 3, 5, 0), 8'b10000001, 8'b11100111, 8'b11111111, 8'b00000000, 8);
      tbl[2] = mk(0, pack4(1, 0, 2, 1), 2'b11, 2'b00, 2'b11, 2'b11, 2);
      tbl[3] = mk(3, pack4(1, 2, 3, 0), 6'b100001, 6'b110011, 6'b111111, 6'b000000, 6);

      reset      = 1'b1;
      enable     = 1'b1;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_duty   = '0;
      repeat (3) step();
      chk("reset_pwm", int'(pwm_out), 0);
      chk("reset_ps", int'(period_start), 0);
      chk("reset_ready", int'(cfg_ready), 0);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", int'(cfg_ready), 1);

      // default period: 2*1023 cycles between period_start pulses
      wait_ps();
      n = 0;
      do begin
         step();
         n++;
      end while (!period_start && n < 5000);
      chk("default_period_len", n, 2046);

      for (int e = 0; e < 4; e++) begin
         load(int'(tbl[e].period), tbl[e].duty);
         capture(int'(tbl[e].len), got);
         for (int c = 0; c < CH; c++)
            cmp_pat($sformatf("tbl%0d_ch%0d", e, c), int'(got[c*16 +: 16]), int'(tbl[e].pat[c*16 +: 16]));
      end

      // cfg change mid down-phase: current period untouched
      load(4, pack4(0, 2, 4, 7));
      pat1 = '0;
      for (int j = 0; j < 8; j++) begin
         pat1 = {pat1[14:0], pwm_out[1]};
         if (j == 4) begin
            cfg_period = W'(4);
            cfg_duty   = pack4(0, 1, 4, 7);
            cfg_valid  = 1'b1;
            chk("middown_ready", int'(cfg_ready), 1);
         end
         if (j < 7) step();
         cfg_valid = 1'b0;
      end
      cmp_pat("middown_cur", int'(pat1), 8'b11000011);
      wait_ps();
      capture(8, got);
      cmp_pat("middown_next", int'(got[16 +: 16]), 8'b10000001);

      // second offer while pending waits for the commit
      offer(4, pack4(2, 2, 2, 2));
      cfg_period = W'(4);
      cfg_duty   = pack4(1, 1, 1, 1);
      cfg_valid  = 1'b1;
      chk("pending_not_ready", int'(cfg_ready), 0);
      wait_ready();
      step();
      cfg_valid = 1'b0;
      chk("accept_then_ps", int'(period_start), 1);
      capture(8, got);
      cmp_pat("held_a_ch0", int'(got[15:0]), 8'b11000011);
      wait_ready();
      wait_ps();
      capture(8, got);
      cmp_pat("second_b_ch0", int'(got[15:0]), 8'b10000001);

      // enable low mid-period
      load(4, pack4(3, 3, 3, 3));
      repeat (2) step();
      enable = 1'b0;
      step();
      chk("disable_pwm", int'(pwm_out), 0);
      chk("disable_ps", int'(period_start), 0);
      repeat (2) step();
      enable = 1'b1;
      step();
      chk("ps_after_enable", int'(period_start), 1);
      repeat (3) step();

      // reset mid-period with a pending shadow
      offer(5, pack4(3, 3, 3, 3));
      repeat (2) step();
      reset = 1'b1;
      step();
      chk("midreset_ready", int'(cfg_ready), 0);
      step();
      reset = 1'b0;
      #1;
      chk("midreset_ready_after", int'(cfg_ready), 1);
      wait_ps();
      n = 0;
      do begin
         step();
         n++;
      end while (!period_start && n < 5000);
      chk("midreset_period_len", n, 2046);

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         reset      = ($urandom % 200) == 0;
         enable     = ($urandom % 16) != 0;
         cfg_valid  = ($urandom % 4) == 0;
         cfg_period = W'($urandom_range(0, 6));
         cfg_duty   = pack4($urandom_range(0, 8), $urandom_range(0, 8),
                            $urandom_range(0, 8), $urandom_range(0, 8));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
